// File: rtl/cdb_scheduler.sv
// cdb_scheduler: shares two registered CDB slots among four completion sources
// (0=mult, 1=mem, 2=alu0, 3=alu1). A losing source is parked in a one-entry
// holding register and stalled until that entry is granted.
// Optional build macro CDB_FIXED_PRIO_EN: fixed priority mult > mem > alu0 > alu1
// with no round-robin pointer; otherwise round-robin arbitration.
module cdb_scheduler #(
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_CDB = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic [3:0]               ex_valid,
  input  logic [4*TAG_W-1:0]       ex_tag,
  input  logic [4*XLEN-1:0]        ex_value,
  output logic [3:0]               stall_out,
  output logic [NUM_CDB-1:0]       cdb_valid,
  output logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  output logic [NUM_CDB*XLEN-1:0]  cdb_value
);

  if (NUM_CDB != 2) begin : g_bad_num_cdb
    $error("cdb_scheduler: only NUM_CDB=2 is supported");
  end

  logic [3:0]                       h_valid_q, h_valid_d;
  logic [3:0][TAG_W-1:0]            h_tag_q, h_tag_d;
  logic [3:0][XLEN-1:0]             h_value_q, h_value_d;
  logic [NUM_CDB-1:0]               cdb_valid_q, cdb_valid_d;
  logic [NUM_CDB-1:0][TAG_W-1:0]    cdb_tag_q, cdb_tag_d;
  logic [NUM_CDB-1:0][XLEN-1:0]     cdb_value_q, cdb_value_d;

  logic [3:0]             cand_valid;
  logic [3:0][TAG_W-1:0]  cand_tag;
  logic [3:0][XLEN-1:0]   cand_value;
  logic [1:0]             scan_start;
  logic [1:0]             scan_idx;
  logic [1:0]             grant_vld;
  logic [1:0][1:0]        grant_src;
  logic [3:0]             granted;
  logic [1:0]             last_src;

  // Candidate per source: a parked packet shadows the live ex inputs.
  always_comb begin
    cand_valid = '0;
    cand_tag   = '0;
    cand_value = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand_valid[i] = h_valid_q[i] | ex_valid[i];
      cand_tag[i]   = h_valid_q[i] ? h_tag_q[i]   : ex_tag[i*TAG_W +: TAG_W];
      cand_value[i] = h_valid_q[i] ? h_value_q[i] : ex_value[i*XLEN +: XLEN];
    end
  end

  // Scan from scan_start; first two candidates take slots 0 and 1.
  always_comb begin
    scan_idx  = '0;
    grant_vld = '0;
    grant_src = '0;
    granted   = '0;
    last_src  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      scan_idx = scan_start + 2'(k);
      if (cand_valid[scan_idx]) begin
        if (!grant_vld[0]) begin
          grant_vld[0]      = 1'b1;
          grant_src[0]      = scan_idx;
          granted[scan_idx] = 1'b1;
          last_src          = scan_idx;
        end else if (!grant_vld[1]) begin
          grant_vld[1]      = 1'b1;
          grant_src[1]      = scan_idx;
          granted[scan_idx] = 1'b1;
          last_src          = scan_idx;
        end
      end
    end
  end

`ifdef CDB_FIXED_PRIO_EN
  assign scan_start = 2'd0;
`else
  logic [1:0] rr_q, rr_d;

  // Pointer moves past the last granted source; holds when nothing is granted.
  always_comb begin
    rr_d = rr_q;
    if (squash) begin
      rr_d = '0;
    end else if (|grant_vld) begin
      rr_d = last_src + 2'd1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  assign scan_start = rr_q;
`endif

  // Holding-register and CDB slot next state; squash overrides everything.
  always_comb begin
    h_valid_d   = h_valid_q;
    h_tag_d     = h_tag_q;
    h_value_d   = h_value_q;
    cdb_valid_d = '0;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (granted[i]) begin
        h_valid_d[i] = 1'b0;
      end else if (!h_valid_q[i] && ex_valid[i]) begin
        h_valid_d[i] = 1'b1;
        h_tag_d[i]   = ex_tag[i*TAG_W +: TAG_W];
        h_value_d[i] = ex_value[i*XLEN +: XLEN];
      end
    end
    for (int unsigned k = 0; k < 2; k++) begin
      if (grant_vld[k]) begin
        cdb_valid_d[k] = 1'b1;
        cdb_tag_d[k]   = cand_tag[grant_src[k]];
        cdb_value_d[k] = cand_value[grant_src[k]];
      end
    end
    if (squash) begin
      h_valid_d   = '0;
      cdb_valid_d = '0;
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_valid_q   <= '0;
      h_tag_q     <= '0;
      h_value_q   <= '0;
      cdb_valid_q <= '0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else begin
      h_valid_q   <= h_valid_d;
      h_tag_q     <= h_tag_d;
      h_value_q   <= h_value_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  assign stall_out = h_valid_q;
  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_value_q;

endmodule

// File: tb/tb_cdb_scheduler.sv
// tb_cdb_scheduler: directed and random stimulus for cdb_scheduler, checked
// against a queue-based model of the sharing rules plus a broadcast scoreboard.
module tb_cdb_scheduler;
  localparam int TW = 6;
  localparam int XW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          squash;
  logic [3:0]    ex_valid;
  logic [4*TW-1:0] ex_tag;
  logic [4*XW-1:0] ex_value;
  logic [3:0]    stall_out;
  logic [1:0]    cdb_valid;
  logic [2*TW-1:0] cdb_tag;
  logic [2*XW-1:0] cdb_value;

  cdb_scheduler #(.TAG_W(TW), .XLEN(XW), .NUM_CDB(2)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .ex_valid(ex_valid), .ex_tag(ex_tag), .ex_value(ex_value),
    .stall_out(stall_out), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_value(cdb_value));

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int serial = 32'h100;

  // model state
  bit          m_hv[4];
  logic [5:0]  m_ht[4];
  logic [31:0] m_hx[4];
  int          m_rr;
  bit          m_cv[2];
  logic [5:0]  m_ct[2];
  logic [31:0] m_cx[2];

  // scoreboard keyed by unique packet value
  bit exp_once[int];
  int bcast[int];
  int lost[$];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic set_src(input int s, input bit v, input logic [5:0] t, input logic [31:0] x);
    ex_valid[s] = v;
    ex_tag[s*TW +: TW] = t;
    ex_value[s*XW +: XW] = x;
  endtask

  // Fresh packet unless the source is stalled (then upstream holds it).
  task automatic drive_src(input int s, input bit v);
    logic [31:0] sv;
    if (!m_hv[s]) begin
      serial++;
      sv = serial;
      set_src(s, v, sv[5:0], sv);
    end
  endtask

  task automatic model_flush(input bit is_reset);
    for (int s = 0; s < 4; s++) begin
      if (m_hv[s]) begin
        exp_once.delete(m_hx[s]);
        lost.push_back(m_hx[s]);
      end
      m_hv[s] = 0;
      if (is_reset) begin m_ht[s] = '0; m_hx[s] = '0; end
    end
    m_rr = 0;
    for (int j = 0; j < 2; j++) begin
      m_cv[j] = 0;
      if (is_reset) begin m_ct[j] = '0; m_cx[j] = '0; end
    end
  endtask

  // Apply one clock edge of the sharing rules to the model.
  task automatic model_edge();
    int cand[$];
    logic [5:0]  ctag[4];
    logic [31:0] cval[4];
    int start;
    if (squash) begin
      model_flush(1'b0);
      return;
    end
    for (int s = 0; s < 4; s++) begin
      ctag[s] = m_hv[s] ? m_ht[s] : ex_tag[s*TW +: TW];
      cval[s] = m_hv[s] ? m_hx[s] : ex_value[s*XW +: XW];
      if (!m_hv[s] && ex_valid[s]) exp_once[cval[s]] = 1;
    end
`ifdef CDB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_rr;
`endif
    for (int k = 0; k < 4; k++) begin
      int s;
      s = (start + k) % 4;
      if (m_hv[s] || ex_valid[s]) cand.push_back(s);
    end
    for (int j = 0; j < 2; j++) begin
      if (j < cand.size()) begin
        m_cv[j] = 1;
        m_ct[j] = ctag[cand[j]];
        m_cx[j] = cval[cand[j]];
      end else begin
        m_cv[j] = 0;
      end
    end
    foreach (cand[n]) begin
      int s;
      s = cand[n];
      if (n < 2) m_hv[s] = 0;
      else if (!m_hv[s]) begin
        m_hv[s] = 1; m_ht[s] = ctag[s]; m_hx[s] = cval[s];
      end
    end
    if (cand.size() > 0) m_rr = (cand[(cand.size() > 1 ? 2 : 1) - 1] + 1) % 4;
  endtask

  task automatic check_outputs();
    chk("cdb_valid", 64'(cdb_valid), 64'({m_cv[1], m_cv[0]}));
    chk("stall_out", 64'(stall_out), 64'({m_hv[3], m_hv[2], m_hv[1], m_hv[0]}));
    for (int j = 0; j < 2; j++) begin
      if (m_cv[j]) begin
        chk($sformatf("slot%0d_tag", j), 64'(cdb_tag[j*TW +: TW]), 64'(m_ct[j]));
        chk($sformatf("slot%0d_value", j), 64'(cdb_value[j*XW +: XW]), 64'(m_cx[j]));
      end
    end
    if (cdb_valid == 2'b11)
      chk("slot_distinct", 64'(cdb_value[31:0] != cdb_value[63:32]), 64'd1);
    for (int j = 0; j < 2; j++) begin
      if (cdb_valid[j]) begin
        int v;
        v = int'(cdb_value[j*XW +: XW]);
        if (bcast.exists(v)) bcast[v]++;
        else bcast[v] = 1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  initial begin
    reset = 1'b1; squash = 1'b0; ex_valid = '0; ex_tag = '0; ex_value = '0;
    model_flush(1'b1);
    @(posedge clock); #1;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_stall", 64'(stall_out), 64'd0);
    chk("rst_tag", 64'(cdb_tag), 64'd0);
    chk("rst_value", 64'(cdb_value), 64'd0);
    reset = 1'b0;

    // single alu1 request lands in slot 0
    set_src(3, 1, 6'd4, 32'h44);
    tick();
    chk("single_valid", 64'(cdb_valid), 64'b01);
    chk("single_tag", 64'(cdb_tag[5:0]), 64'd4);
    chk("single_value", 64'(cdb_value[31:0]), 64'h44);
    chk("single_stall", 64'(stall_out), 64'd0);
    ex_valid = '0;

    // all four at rr=0: mult/mem win, alu0/alu1 park, then drain
    for (int s = 0; s < 4; s++) set_src(s, 1, 6'(s + 1), 32'h1000 + 32'(s + 1));
    tick();
    chk("all4_c1_valid", 64'(cdb_valid), 64'b11);
    chk("all4_c1_s0", 64'(cdb_tag[5:0]), 64'd1);
    chk("all4_c1_s1", 64'(cdb_tag[11:6]), 64'd2);
    chk("all4_c1_stall", 64'(stall_out), 64'b1100);
    set_src(0, 0, 0, 0); set_src(1, 0, 0, 0);
    tick();
    chk("all4_c2_s0", 64'(cdb_tag[5:0]), 64'd3);
    chk("all4_c2_s1", 64'(cdb_tag[11:6]), 64'd4);
    chk("all4_c2_stall", 64'(stall_out), 64'b0000);
    ex_valid = '0;
    tick();
    chk("idle_valid", 64'(cdb_valid), 64'b00);

    // park alu0, then reset mid-cycle clears without a clock edge
    for (int s = 0; s < 3; s++) set_src(s, 1, 6'(s + 8), 32'h2000 + 32'(s));
    tick();
    chk("park_alu0", 64'(stall_out), 64'b0100);
    ex_valid = '0;
    #1 reset = 1'b1;
    #1;
    model_flush(1'b1);
    chk("async_rst_stall", 64'(stall_out), 64'd0);
    chk("async_rst_valid", 64'(cdb_valid), 64'd0);
    chk("async_rst_value", 64'(cdb_value), 64'd0);
    #1 reset = 1'b0;

    // first grant after reset starts at mult; then park 13,14 and squash
    for (int s = 0; s < 4; s++) set_src(s, 1, 6'(s + 11), 32'h3000 + 32'(s));
    tick();
    chk("post_rst_s0", 64'(cdb_tag[5:0]), 64'd11);
    chk("post_rst_stall", 64'(stall_out), 64'b1100);
    ex_valid = '0;
    squash = 1'b1;
    set_src(0, 1, 6'd40, 32'h3f00);
    tick();
    squash = 1'b0;
    ex_valid = '0;
    chk("squash_valid", 64'(cdb_valid), 64'b00);
    chk("squash_stall", 64'(stall_out), 64'b0000);
    tick();
    chk("post_squash_idle", 64'(cdb_valid), 64'b00);
    for (int s = 0; s < 4; s++) set_src(s, 1, 6'(s + 21), 32'h4000 + 32'(s));
    tick();
    chk("post_squash_rr0", 64'(cdb_tag[5:0]), 64'd21);
    ex_valid = '0;
    tick();
    tick();

`ifdef CDB_FIXED_PRIO_EN
    // fixed priority: alu0 starves while mult and mem keep requesting
    drive_src(0, 1); drive_src(1, 1);
    serial++; set_src(2, 1, 6'd3, serial);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive_src(0, 1); drive_src(1, 1);
      tick();
      chk("starve_stall2", 64'(stall_out[2]), 64'd1);
      chk("starve_both", 64'(cdb_valid), 64'b11);
    end
    drive_src(0, 1); set_src(1, 0, 0, 0);
    tick();
    chk("starve_release_tag", 64'(cdb_tag[11:6]), 64'd3);
    chk("starve_release_stall", 64'(stall_out[2]), 64'd0);
    ex_valid = '0;
    tick();
`endif

    // sweep all 16 request patterns, then random traffic, then drain
    for (int p = 0; p < 16; p++) begin
      for (int s = 0; s < 4; s++) drive_src(s, p[s]);
      tick();
    end
    for (int c = 0; c < 200; c++) begin
      for (int s = 0; s < 4; s++) drive_src(s, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) squash = 1'b1;
      tick();
      squash = 1'b0;
    end
    for (int s = 0; s < 4; s++) if (!m_hv[s]) ex_valid[s] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int s = 0; s < 4; s++) if (!m_hv[s]) ex_valid[s] = 1'b0;
      tick();
    end

    // every accepted packet broadcast exactly once; dropped ones never
    foreach (exp_once[v])
      chk($sformatf("once_%0h", v), 64'(bcast.exists(v) ? bcast[v] : 0), 64'd1);
    foreach (lost[n])
      chk($sformatf("lost_%0h", lost[n]), 64'(bcast.exists(lost[n]) ? bcast[lost[n]] : 0), 64'd0);
    chk("bcast_count", 64'(bcast.num()), 64'(exp_once.num()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
